// File: rtl/inst_mem_responder_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
// The default depth and latency are also consumed by the fetch stage.
package inst_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          WORD_OFFSET_BITS = 2;
    localparam logic [31:0] ERR_DATA         = 32'h0000_0000;
    localparam int          DEFAULT_DEPTH    = 1024;
    localparam int          DEFAULT_LATENCY  = 2;
    // Wide enough for the largest legal latency of 15.
    localparam int          CNT_W            = 4;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response handshake bundle between the fetch stage (master)
// and the instruction-memory responder (slave).
interface inst_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/inst_mem_array.sv
// Program storage: one synchronous write port and one synchronous read port,
// where a read and a write to the same word on one edge return the old word.
module inst_mem_array #(
    parameter  int DEPTH  = 1024,
    parameter  int DATA_W = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    // NOTE: the storage has no reset; program words survive rst_n and only
    // the load port changes them, which also keeps this mappable to RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: both updates are non-blocking, so on a same-word collision the
    // read samples the value from before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Latency-accurate instruction-memory slave: accepts one fetch at a time and
// answers after LATENCY wait cycles, flagging misaligned/out-of-range fetches.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int LATENCY = DEFAULT_LATENCY,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_mem_responder_if.slave   bus,
    input  logic                  load_en,
    input  logic [AW-1:0]         load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  busy
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  word_idx;
    logic               err_q;
    logic               dec_err;
    logic               accept;
    logic               handshake;
    logic               enter_resp;
    logic               mem_we;
    logic [DATA_W-1:0]  rd_data;

    // With zero latency the decode happens on the accept edge itself, so it
    // must look at the live request address rather than the latched one.
    assign cur_addr = (state == IDLE) ? bus.req_addr : addr_q;
    assign word_idx = cur_addr >> WORD_OFFSET_BITS;
    assign dec_err  = (cur_addr[WORD_OFFSET_BITS-1:0] != '0)
                   || (word_idx >= ADDR_W'(DEPTH));

    assign accept    = bus.req_valid && bus.req_ready;
    assign handshake = bus.resp_valid && bus.resp_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        enter_resp    = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = rst_n;
                if (bus.req_valid && rst_n) begin
                    if (LATENCY == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= bus.req_addr;
                cnt    <= CNT_W'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (enter_resp) begin
                err_q <= dec_err;
            end else if (handshake) begin
                err_q <= 1'b0;
            end
        end
    end

    assign mem_we = rst_n && load_en && (32'(load_addr) < DEPTH);

    inst_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (enter_resp && !dec_err),
        .rd_addr (word_idx[AW-1:0]),
        .rd_data (rd_data)
    );

    // The read register only updates on a clean RESP entry, so masking it
    // here keeps the response at zero for errors and after reset.
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = err_q;
    assign bus.resp_data  = ((state == RESP) && !err_q) ? rd_data
                                                        : DATA_W'(ERR_DATA);
    assign busy           = (state != IDLE);

endmodule
